// File: rtl/load_extend_pipe_pkg.sv
// Shared constants and helpers for the MEM->WB load-data extender.
package load_extend_pipe_pkg;

    localparam int SZW  = 2;
    localparam int TAGW = 5;

    localparam logic [SZW-1:0] SZ_BYTE = 2'b00;
    localparam logic [SZW-1:0] SZ_HALF = 2'b01;
    localparam logic [SZW-1:0] SZ_WORD = 2'b10;
    localparam logic [SZW-1:0] SZ_RSVD = 2'b11;

    typedef logic [SZW-1:0]  size_t;
    typedef logic [TAGW-1:0] tag_t;

    // Halfwords must sit on an even byte, words on offset 0; the reserved size is never valid.
    function automatic logic is_misaligned(input size_t size, input logic off_lsb, input logic off_nonzero);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off_lsb;
            SZ_WORD: bad = off_nonzero;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend_pipe_lane_extend.sv
// Combinational lane select plus sign/zero fill; misaligned or reserved accesses yield zero data.
module load_extend_pipe_lane_extend
    import load_extend_pipe_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OFFW = $clog2(DW/8)
) (
    input  logic [DW-1:0]   rdata_i,
    input  logic [OFFW-1:0] off_i,
    input  logic [SZW-1:0]  size_i,
    input  logic            signed_i,
    output logic [DW-1:0]   data_o,
    output logic            misal_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        misal_s;

    // Shift the addressed byte down to bit 0 (little-endian lanes) and keep only the low lanes.
    always_comb begin
        byte_s = 8'(rdata_i >> {off_i, 3'b000});
        half_s = 16'(rdata_i >> {off_i, 3'b000});
    end

    // Extend the selected lane; a misaligned result is forced to zero.
    always_comb begin
        data_o  = '0;
        misal_s = is_misaligned(size_i, off_i[0], off_i != '0);
        if (misal_s) begin
            data_o = '0;
        end else begin
            case (size_i)
                SZ_BYTE: data_o = {{(DW-8){signed_i & byte_s[7]}}, byte_s};
                SZ_HALF: data_o = {{(DW-16){signed_i & half_s[15]}}, half_s};
                SZ_WORD: data_o = rdata_i;
                default: data_o = '0;
            endcase
        end
        misal_o = misal_s;
    end

endmodule

// File: rtl/load_extend_pipe.sv
// Registered load extender with a two-slot (MAIN + SKID) ready/valid buffer; in_ready depends
// only on registered state, so WB back-pressure never forms a combinational path upstream.
module load_extend_pipe
    import load_extend_pipe_pkg::*;
#(
    parameter  int DW   = 32,
    localparam int OFFW = $clog2(DW/8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_rdata,
    input  logic [OFFW-1:0] in_offset,
    input  logic [1:0]      in_size,
    input  logic            in_signed,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [4:0]      out_rd,
    output logic            out_misal
);

    logic [DW-1:0] ext_data_s;
    logic          ext_misal_s;
    logic          acc_s;
    logic          drain_s;

    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] main_data_q,  main_data_d;
    tag_t          main_rd_q,    main_rd_d;
    logic          main_misal_q, main_misal_d;

    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q,  skid_data_d;
    tag_t          skid_rd_q,    skid_rd_d;
    logic          skid_misal_q, skid_misal_d;

    load_extend_pipe_lane_extend #(
        .DW   (DW),
        .OFFW (OFFW)
    ) u_lane_extend (
        .rdata_i  (in_rdata),
        .off_i    (in_offset),
        .size_i   (in_size),
        .signed_i (in_signed),
        .data_o   (ext_data_s),
        .misal_o  (ext_misal_s)
    );

    // Handshake qualifiers; an occupied SKID is the only reason to refuse a beat.
    always_comb begin
        acc_s   = in_valid & ~skid_valid_q;
        drain_s = main_valid_q & out_ready;
    end

    // Slot next-state: SKID refills MAIN first to keep FIFO order, new beats bypass to MAIN when possible.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_rd_d    = main_rd_q;
        main_misal_d = main_misal_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_rd_d    = skid_rd_q;
        skid_misal_d = skid_misal_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            main_rd_d    = '0;
            main_misal_d = 1'b0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_rd_d    = '0;
            skid_misal_d = 1'b0;
        end else if (!main_valid_q || drain_s) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_rd_d    = skid_rd_q;
                main_misal_d = skid_misal_q;
                skid_valid_d = 1'b0;
            end else if (acc_s) begin
                main_valid_d = 1'b1;
                main_data_d  = ext_data_s;
                main_rd_d    = in_rd;
                main_misal_d = ext_misal_s;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (acc_s) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_data_s;
            skid_rd_d    = in_rd;
            skid_misal_d = ext_misal_s;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_rd_q    <= '0;
            main_misal_q <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_rd_q    <= '0;
            skid_misal_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_rd_q    <= main_rd_d;
            main_misal_q <= main_misal_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_rd_q    <= skid_rd_d;
            skid_misal_q <= skid_misal_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        in_ready  = ~skid_valid_q;
        out_valid = main_valid_q;
        out_data  = main_data_q;
        out_rd    = main_rd_q;
        out_misal = main_misal_q;
    end

endmodule

// File: tb/tb_load_extend_pipe.sv
// Directed and scoreboard bench for load_extend_pipe (DW=32 main instance, DW=64 spot checks).
module tb_load_extend_pipe;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        misal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_misal;
    logic [31:0] in_rdata, out_data;
    logic [1:0]  in_offset, in_size;
    logic [4:0]  in_rd, out_rd;

    logic        v64, rdy64, sgn64, ov64, or64, om64;
    logic [63:0] rdata64, od64;
    logic [2:0]  off64;
    logic [1:0]  size64;
    logic [4:0]  rd64, ord64;

    int          tests_run = 0;
    int          fails = 0;
    int          sent;
    logic        acc;
    exp_t        sb[$];
    exp_t        got;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [4:0]  prev_rd;
    logic        prev_misal;

    load_extend_pipe #(.DW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_rdata(in_rdata), .in_offset(in_offset),
        .in_size(in_size), .in_signed(in_signed), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_misal(out_misal)
    );

    load_extend_pipe #(.DW(64)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(v64), .in_ready(rdy64), .in_rdata(rdata64), .in_offset(off64),
        .in_size(size64), .in_signed(sgn64), .in_rd(rd64),
        .out_valid(ov64), .out_ready(1'b1), .out_data(od64), .out_rd(ord64),
        .out_misal(om64)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] rdata, input logic [1:0] off, input logic [1:0] size,
                                   input logic sgn, input logic [4:0] tag);
        exp_t        e;
        logic [31:0] sh;
        sh      = rdata >> (8 * off);
        e.rd    = tag;
        e.misal = 1'b0;
        e.data  = 32'h0;
        case (size)
            2'b00: e.data = (sgn && sh[7])  ? {24'hFFFFFF, sh[7:0]}  : {24'h0, sh[7:0]};
            2'b01: if (off[0]) e.misal = 1'b1;
                   else e.data = (sgn && sh[15]) ? {16'hFFFF, sh[15:0]} : {16'h0, sh[15:0]};
            2'b10: if (off != 2'd0) e.misal = 1'b1; else e.data = rdata;
            default: e.misal = 1'b1;
        endcase
        return e;
    endfunction

    // One clock: sample at negedge (scoreboard + stall stability), then advance past posedge.
    task automatic tick();
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(prev_data));
            chk("stall_rd", 64'(out_rd), 64'(prev_rd));
            chk("stall_misal", 64'(out_misal), 64'(prev_misal));
        end
        prev_stall = out_valid && !out_ready && !rst && !flush;
        prev_data  = out_data;
        prev_rd    = out_rd;
        prev_misal = out_misal;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                tests_run++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_out observed rd=%0d expected no beat", out_rd);
                end
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    chk("sb_data", 64'(out_data), 64'(got.data));
                    chk("sb_rd", 64'(out_rd), 64'(got.rd));
                    chk("sb_misal", 64'(out_misal), 64'(got.misal));
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(model(in_rdata, in_offset, in_size, in_signed, in_rd));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                        input logic sg, input logic [4:0] tag);
        in_valid = 1'b1; in_rdata = d; in_offset = off; in_size = sz; in_signed = sg; in_rd = tag;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send64(input logic [2:0] off, input logic [1:0] sz, input logic sg,
                          input logic [63:0] exp_d, input logic exp_m, input string tag);
        v64 = 1'b1; off64 = off; size64 = sz; sgn64 = sg;
        @(posedge clk);
        #1;
        v64 = 1'b0;
        chk({tag, "_valid"}, 64'(ov64), 64'd1);
        chk({tag, "_data"}, od64, exp_d);
        chk({tag, "_misal"}, 64'(om64), 64'(exp_m));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rdata = 32'h0; in_offset = 2'd0;
        in_size = 2'd0; in_signed = 1'b0; in_rd = 5'd0; out_ready = 1'b1;
        v64 = 1'b0; rdata64 = 64'h8081_F27F_0000_0000; off64 = 3'd0; size64 = 2'd0; sgn64 = 1'b0;
        rd64 = 5'd1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_misal", 64'(out_misal), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Extension cases, one-cycle latency, back-to-back
        send(32'h8081_F27F, 2'd0, 2'b00, 1'b1, 5'd1);
        chk("t1_b0_valid", 64'(out_valid), 64'd1);
        chk("t1_b0_data", 64'(out_data), 64'h0000_007F);
        send(32'h8081_F27F, 2'd1, 2'b00, 1'b1, 5'd2);
        chk("t1_b1_data", 64'(out_data), 64'hFFFF_FFF2);
        send(32'h8081_F27F, 2'd2, 2'b01, 1'b0, 5'd3);
        chk("t2_hu_data", 64'(out_data), 64'h0000_8081);
        send(32'h8081_F27F, 2'd2, 2'b01, 1'b1, 5'd4);
        chk("t2_hs_data", 64'(out_data), 64'hFFFF_8081);
        send(32'h8081_F27F, 2'd1, 2'b01, 1'b1, 5'd5);
        chk("t2_hmis_misal", 64'(out_misal), 64'd1);
        chk("t2_hmis_data", 64'(out_data), 64'd0);
        chk("t2_hmis_rd", 64'(out_rd), 64'd5);
        send(32'h8081_F27F, 2'd0, 2'b11, 1'b0, 5'd6);
        chk("rsvd_misal", 64'(out_misal), 64'd1);
        send(32'h8081_F27F, 2'd0, 2'b10, 1'b1, 5'd7);
        chk("word_data", 64'(out_data), 64'h8081_F27F);
        send(32'h8081_F27F, 2'd2, 2'b10, 1'b0, 5'd8);
        chk("word_mis", 64'(out_misal), 64'd1);
        tick();

        // Back-pressure fills MAIN then SKID
        out_ready = 1'b0;
        send(32'h1234_5678, 2'd0, 2'b00, 1'b0, 5'd3);
        send(32'h1234_5678, 2'd3, 2'b00, 1'b0, 5'd4);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        chk("t3_rd_head", 64'(out_rd), 64'd3);
        tick(); tick();
        out_ready = 1'b1;
        tick();
        chk("t3_rd_next", 64'(out_rd), 64'd4);
        chk("t3_ready_back", 64'(in_ready), 64'd1);
        tick();
        chk("t3_empty", 64'(out_valid), 64'd0);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Continuous stream with toggling out_ready
        sent = 0;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            in_valid  = 1'b1;
            in_rdata  = $urandom;
            in_offset = 2'($urandom_range(0, 3));
            in_size   = 2'($urandom_range(0, 3));
            in_signed = 1'($urandom_range(0, 1));
            in_rd     = 5'(sent);
            out_ready = (c % 2 == 0) ? 1'b1 : 1'b0;
            acc = in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
        chk("t4_sent", 64'(sent), 64'd20);
        chk("t4_drained", 64'(sb.size()), 64'd0);

        // Flush with both slots full, and flush dropping a same-cycle accept
        out_ready = 1'b0;
        send(32'hAAAA_5555, 2'd0, 2'b00, 1'b0, 5'd7);
        send(32'hAAAA_5555, 2'd1, 2'b00, 1'b0, 5'd8);
        flush = 1'b1; in_valid = 1'b1; in_rd = 5'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        send(32'h0000_00FF, 2'd0, 2'b00, 1'b1, 5'd11);
        flush = 1'b1; in_valid = 1'b1; in_rd = 5'd10; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5b_valid", 64'(out_valid), 64'd0);
        tick(); tick(); tick();
        chk("t5_quiet", 64'(out_valid), 64'd0);

        // Reset mid-stream with beats held
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 2'd0, 2'b10, 1'b0, 5'd12);
        send(32'hDEAD_BEEF, 2'd2, 2'b01, 1'b1, 5'd13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_data", 64'(out_data), 64'd0);
        chk("t6_rd", 64'(out_rd), 64'd0);
        chk("t6_misal", 64'(out_misal), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        // Wide-bus lane selection
        send64(3'd4, 2'b00, 1'b1, 64'h0000_0000_0000_007F, 1'b0, "w64_b4s");
        send64(3'd5, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, "w64_b5s");
        send64(3'd5, 2'b00, 1'b0, 64'h0000_0000_0000_00F2, 1'b0, "w64_b5u");
        send64(3'd6, 2'b01, 1'b0, 64'h0000_0000_0000_8081, 1'b0, "w64_h6u");
        send64(3'd6, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_8081, 1'b0, "w64_h6s");
        send64(3'd5, 2'b01, 1'b1, 64'h0, 1'b1, "w64_h5mis");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
